// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, class decode and default latencies for muldiv_unit
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               ((op >= OP_MADD) && (op <= OP_MSUBU));
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_move(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_compute.sv
// rtl/muldiv_compute.sv - combinational 2*WIDTH multiply/accumulate/divide result
module muldiv_compute
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] prod;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV) ||
                    (op == OP_MADD) || (op == OP_MSUB);
        acc       = {hi, lo};
        // Extending to full width makes the truncated product exact in both signednesses
        prod_s    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        prod      = signed_op ? prod_s : prod_u;

        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        b_zero    = (b == '0);
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        divisor   = b_zero ? WIDTH'(1) : mag_b;
        q_mag     = mag_a / divisor;
        r_mag     = mag_a % divisor;
        // MIN_INT / -1 falls out naturally: |MIN_INT| / 1 = MIN_INT, signs agree, rem 0
        quot      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem       = a_neg ? -r_mag : r_mag;

        case (op)
            OP_MULT, OP_MULTU: result = prod;
            OP_DIV, OP_DIVU:   result = b_zero ? {a, {WIDTH{1'b1}}} : {rem, quot};
            OP_MADD, OP_MADDU: result = acc + prod;
            OP_MSUB, OP_MSUBU: result = acc - prod;
            default:           result = acc;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with fixed-latency countdown and flush
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   counter_nxt;
    logic [2*WIDTH-1:0] tmp;
    logic [2*WIDTH-1:0] tmp_nxt;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;
    logic               done_nxt;

    muldiv_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .a      (a),
        .b      (b),
        .op     (op),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            tmp     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            tmp     <= tmp_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        tmp_nxt     = tmp;
        hi_nxt      = hi;
        lo_nxt      = lo;
        done_nxt    = 1'b0;

        // flush outranks every other action, including the final commit edge
        if (flush) begin
            state_nxt   = ST_IDLE;
            counter_nxt = '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    counter_nxt = counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        {hi_nxt, lo_nxt} = tmp;
                        state_nxt        = ST_IDLE;
                        done_nxt         = 1'b1;
                    end
                end
                default: begin
                    if (start && (is_mul(op) || is_div(op))) begin
                        tmp_nxt     = result;
                        counter_nxt = is_div(op) ? DIV_CNT : MUL_CNT;
                        state_nxt   = ST_BUSY;
                    end else if (!start && is_move(op)) begin
                        if (op == OP_MTHI) begin
                            hi_nxt = a;
                        end else begin
                            lo_nxt = a;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised successor of the pipeline's HI/LO multiply/divide unit; sits beside the EX-stage ALU.
- Accepts one operation at a time and holds the result in architectural HI/LO registers.
- New relative to the current unit:
  - WIDTH and per-class latencies are parameters.
  - Adds accumulate ops (MADD/MADDU/MSUB/MSUBU).
  - Defines divide-by-zero and signed-overflow results.
  - Adds a flush input for exception/branch squash and a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, busy cycles for mult/madd/msub class (>=1).
- DIV_LAT, 10, busy cycles for div class (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- op  in  4  operation code (package enum).
- start  in  1  launch op; only accepted when busy=0 and op is an arithmetic op.
- flush  in  1  squash in-flight op and suppress this cycle's writes.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse on the edge HI/LO take a computed result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0 at edge): hi=0, lo=0, busy=0, done=0, counter=0, tmp=0. Reset overrides all other inputs, including mid-operation.
- Op codes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU: class MUL for 0/1, class DIV for 2/3.
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU: class MUL.
  - 8 MTHI, 9 MTLO.
  - Others: NOP.
- Accept: at an edge with busy=0, start=1, flush=0 and an arithmetic op:
  - Compute the 2*WIDTH result into tmp from a, b and the current {hi,lo}.
  - Load counter with MUL_LAT or DIV_LAT; busy<=1.
- Result computation:
  - MULT/MULTU: signed/unsigned a*b.
  - MADD(U): {hi,lo} + a*b. MSUB(U): {hi,lo} - a*b. Arithmetic is modulo 2^(2*WIDTH); signedness applies to the product only.
  - DIV(U): lo=quotient, hi=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - b==0: lo = all ones, hi = a (both signed and unsigned).
  - Signed a=MIN_INT, b=-1: lo=MIN_INT, hi=0.
- Countdown: each edge with busy=1, flush=0 decrements counter. On the edge where counter reaches 0: {hi,lo}<=tmp, busy<=0, done<=1.
  - Busy is therefore high for exactly LAT cycles. done is high in the cycle after busy falls, for one cycle only.
- MTHI/MTLO: at an edge with busy=0, flush=0, start=0, op=MTHI/MTLO: hi<=a or lo<=a. No busy, no done. Ignored while busy.
- start while busy=1: ignored. The op is not queued; the pipeline must stall on busy.
- flush:
  - busy=1: busy<=0 and counter<=0 next edge; hi/lo unchanged; no done.
  - flush together with start or MTHI/MTLO: flush wins, nothing written.
  - flush on the final countdown edge: flush wins, result discarded.
- done defaults to 0 every edge unless set as above.
- A new start is accepted in the cycle busy is low, i.e. the cycle done is high. MADD then reads the freshly written hi/lo.

Decomposition:
- Package muldiv_pkg:
  - op enum (4-bit codes above).
  - Class decode function (is_mul, is_div, is_move).
  - Default latency constants.
- One sub-module muldiv_compute: pure combinational 2*WIDTH result from a, b, op, hi, lo, including divide corner cases. It is instantiated once.
- The top module holds the counter, busy/done control and HI/LO registers.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. Then MADDU a=1, b=2 -> hi=0x00000002, lo=0x00000000.
- DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Start DIV, assert flush in busy cycle 4 -> busy 0 next cycle; hi/lo keep prior values; no done. MTHI a=0x1234 with flush=1 -> hi unchanged.
- During MULT busy: pulse start with DIVU and MTLO a=0xAA -> both ignored; MULT result lands unchanged.
- Assert reset=0 at busy cycle 3 of MSUB -> next edge hi=lo=0, busy=0. With reset released, a start in the same cycle as done is accepted.
